// File: rtl/proximity_monitor.sv
// proximity_monitor: periodic ultrasonic ranging controller with cm conversion, 4-tap average and hysteretic near flag
//
// Ports:
//   CLOCK_50        in   50 MHz clock, all logic on the rising edge
//   rst_n           in   asynchronous active-low reset
//   enable_i        in   high permits new measurements
//   sensor_ready_i  in   sensor idle/done indication
//   distance_raw_i  in   echo-high cycle count, valid while sensor_ready_i high after completion
//   measure_o       out  one-cycle start request to the sensor
//   dist_cm_o       out  latest converted distance in cm
//   avg_cm_o        out  4-sample moving average in cm
//   dist_valid_o    out  one-cycle pulse when dist/avg/near update
//   near_o          out  hysteretic proximity flag
//   timeout_err_o   out  sticky echo-timeout flag
module proximity_monitor #(
    parameter int MEAS_PERIOD   = 3_000_000,
    parameter int CYCLES_PER_CM = 2900,
    parameter int TIMEOUT       = 1_500_000,
    parameter int NEAR_CM       = 20,
    parameter int HYST_CM       = 5
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        sensor_ready_i,
    input  logic [21:0] distance_raw_i,
    output logic        measure_o,
    output logic [9:0]  dist_cm_o,
    output logic [9:0]  avg_cm_o,
    output logic        dist_valid_o,
    output logic        near_o,
    output logic        timeout_err_o
);
    localparam int PW = $clog2(MEAS_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(MEAS_PERIOD - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [21:0]   CPC      = 22'(CYCLES_PER_CM);
    localparam logic [9:0]    NEAR_SET = 10'(NEAR_CM);
    localparam logic [9:0]    NEAR_CLR = 10'(NEAR_CM + HYST_CM);
    localparam logic [9:0]    QUO_MAX  = 10'd1023;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, CONVERT, FILTER} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   per_q, per_d;
    logic [TW-1:0]   to_q, to_d;
    logic [21:0]     rem_q, rem_d;
    logic [9:0]      quo_q, quo_d;
    logic [3:0][9:0] hist_q, hist_d;
    logic            first_q, first_d;
    logic            pub_q, pub_d;
    logic [9:0]      dist_q, dist_d;
    logic [9:0]      avg_q, avg_d;
    logic            valid_q, valid_d;
    logic            near_q, near_d;
    logic            err_q, err_d;
    logic            go;
    logic            waiting;
    logic [11:0]     sum;
    logic [9:0]      avg_new;

    assign go      = enable_i && sensor_ready_i && per_q == PER_LAST;
    assign waiting = state_q == WAIT_BUSY || state_q == WAIT_DONE;
    assign sum     = 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]) + 12'(hist_q[3]);
    assign avg_new = 10'(sum >> 2);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        to_d    = to_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hist_d  = hist_q;
        first_d = first_q;
        pub_d   = 1'b0;
        valid_d = pub_q;
        dist_d  = dist_q;
        avg_d   = avg_q;
        near_d  = near_q;
        err_d   = err_q;
        // Counter reads 0 in the START cycle so successive pulses are exactly MEAS_PERIOD apart
        if (!enable_i || (state_q == IDLE && go)) per_d = '0;
        else if (per_q != PER_LAST)               per_d = per_q + 1'b1;
        if (waiting && to_q != TO_MAX) to_d = to_q + 1'b1;
        if (to_q == TO_MAX) err_d = 1'b1;
        case (state_q)
            IDLE:      state_d = go ? START : IDLE;
            START: begin
                state_d = WAIT_BUSY;
                to_d    = '0;
            end
            WAIT_BUSY: state_d = sensor_ready_i ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: if (sensor_ready_i) begin
                // A sample that completes after the timeout is dropped
                state_d = to_q == TO_MAX ? IDLE : CONVERT;
                rem_d   = distance_raw_i;
                quo_d   = '0;
            end
            CONVERT: if (rem_q >= CPC && quo_q != QUO_MAX) begin
                rem_d = rem_q - CPC;
                quo_d = quo_q + 1'b1;
            end else begin
                state_d = FILTER;
            end
            FILTER: begin
                hist_d  = first_q ? {4{quo_q}} : {hist_q[2:0], quo_q};
                first_d = 1'b0;
                pub_d   = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
        // Publish stage: outputs follow the history registered in FILTER
        if (pub_q) begin
            dist_d = hist_q[0];
            avg_d  = avg_new;
            near_d = avg_new < NEAR_SET ? 1'b1 : avg_new >= NEAR_CLR ? 1'b0 : near_q;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            per_q   <= '0;
            to_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hist_q  <= '0;
            first_q <= 1'b1;
            pub_q   <= 1'b0;
            dist_q  <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            near_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            per_q   <= per_d;
            to_q    <= to_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hist_q  <= hist_d;
            first_q <= first_d;
            pub_q   <= pub_d;
            dist_q  <= dist_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            near_q  <= near_d;
            err_q   <= err_d;
        end
    end

    assign measure_o     = state_q == START;
    assign dist_cm_o     = dist_q;
    assign avg_cm_o      = avg_q;
    assign dist_valid_o  = valid_q;
    assign near_o        = near_q;
    assign timeout_err_o = err_q;
endmodule

// File: tb/tb_proximity_monitor.sv
// tb_proximity_monitor: vector table, corner sequences and random samples against a reference model
module tb_proximity_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        sensor_ready = 1'b1;
    logic [21:0] distance_raw = '0;
    logic        measure_o;
    logic [9:0]  dist_cm_o;
    logic [9:0]  avg_cm_o;
    logic        dist_valid_o;
    logic        near_o;
    logic        timeout_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_meas = 0;

    int m_hist[$];
    bit m_first = 1'b1;
    int m_dist, m_avg;
    int m_near = 0;

    typedef struct {
        logic [21:0] raw;
        int          busy;
        int          e_dist;
        int          e_avg;
        int          e_near;
        int          per;
    } vec_t;

    proximity_monitor #(
        .MEAS_PERIOD(100), .CYCLES_PER_CM(2900), .TIMEOUT(1000), .NEAR_CM(20), .HYST_CM(5)
    ) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .enable_i(enable), .sensor_ready_i(sensor_ready),
        .distance_raw_i(distance_raw), .measure_o(measure_o), .dist_cm_o(dist_cm_o),
        .avg_cm_o(avg_cm_o), .dist_valid_o(dist_valid_o), .near_o(near_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Spec-level model: cm = floor(raw/2900) capped at 1023, mean of last four, near hysteresis 20/25
    function automatic void model_push(input int raw);
        int q, s;
        q = raw / 2900;
        if (q > 1023) q = 1023;
        if (m_first) begin
            m_hist = {q, q, q, q};
            m_first = 1'b0;
        end else begin
            m_hist.push_front(q);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
        s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        m_dist = q;
        m_avg  = s / 4;
        if (m_avg < 20) m_near = 1;
        else if (m_avg >= 25) m_near = 0;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        m_first = 1'b1;
        m_near = 0;
    endfunction

    task automatic run_sample(input string tag, input logic [21:0] raw, input int busy,
                              input int e_dist, input int e_avg, input int e_near, input int per_exp);
        int n;
        n = 0;
        while (!measure_o && n < 3000) begin
            tick();
            n++;
        end
        chk($sformatf("%s_measure_seen", tag), int'(measure_o), 1);
        if (!measure_o) return;
        if (per_exp > 0) chk($sformatf("%s_period", tag), cyc - last_meas, per_exp);
        last_meas = cyc;
        tick();
        chk($sformatf("%s_measure_width", tag), int'(measure_o), 0);
        sensor_ready = 1'b0;
        repeat (busy) tick();
        distance_raw = raw;
        sensor_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dist_valid_o && n < 1200);
        chk($sformatf("%s_latency", tag), n, e_dist + 4);
        chk($sformatf("%s_dist", tag), int'(dist_cm_o), e_dist);
        chk($sformatf("%s_avg", tag), int'(avg_cm_o), e_avg);
        chk($sformatf("%s_near", tag), int'(near_o), e_near);
        chk($sformatf("%s_err", tag), int'(timeout_err_o), 0);
    endtask

    initial begin
        vec_t vecs[11];
        int n, s, rise;
        bit saw;
        vecs = '{
            '{22'd29000,   3, 10,   10,  1, 0},
            '{22'd87000,   3, 30,   15,  1, 100},
            '{22'd87000,   5, 30,   20,  1, 100},
            '{22'd87000,   2, 30,   25,  0, 100},
            '{22'd4000000, 3, 1023, 278, 0, 0},
            '{22'd0,       4, 0,    270, 0, 0},
            '{22'd2899,    3, 0,    263, 0, 100},
            '{22'd55100,   1, 19,   260, 0, 100},
            '{22'd0,       6, 0,    4,   1, 100},
            '{22'd69600,   3, 24,   10,  1, 100},
            '{22'd290000,  2, 100,  35,  0, 100}
        };

        repeat (3) tick();
        chk("rst_measure", int'(measure_o), 0);
        chk("rst_dist", int'(dist_cm_o), 0);
        chk("rst_avg", int'(avg_cm_o), 0);
        chk("rst_valid", int'(dist_valid_o), 0);
        chk("rst_near", int'(near_o), 0);
        chk("rst_err", int'(timeout_err_o), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            model_push(int'(vecs[i].raw));
            run_sample($sformatf("v%0d", i), vecs[i].raw, vecs[i].busy, vecs[i].e_dist,
                       vecs[i].e_avg, vecs[i].e_near, vecs[i].per);
        end

        // Echo timeout: ready held low 2000 cycles, late sample dropped, next good sample clears the flag
        n = 0;
        while (!measure_o && n < 3000) begin
            tick();
            n++;
        end
        chk("to_measure_seen", int'(measure_o), 1);
        s = cyc;
        tick();
        sensor_ready = 1'b0;
        rise = -1;
        saw = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (timeout_err_o && rise < 0) rise = cyc - s;
            if (measure_o) saw = 1'b1;
        end
        chk("to_rise_in_window", int'(rise >= 995 && rise <= 1005), 1);
        chk("to_no_measure_while_waiting", int'(saw), 0);
        distance_raw = 22'd58000;
        sensor_ready = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (dist_valid_o) saw = 1'b1;
            if (measure_o) break;
        end
        chk("to_discard_no_valid", int'(saw), 0);
        chk("to_err_sticky", int'(timeout_err_o), 1);
        model_push(14500);
        run_sample("to_recover", 22'd14500, 3, m_dist, m_avg, m_near, 0);

        for (int i = 0; i < 20; i++) begin
            int raw;
            raw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4194303)) : int'($urandom_range(0, 2900 * 45));
            model_push(raw);
            run_sample($sformatf("r%0d", i), 22'(raw), int'($urandom_range(1, 25)), m_dist, m_avg, m_near, 0);
        end

        // Reset pulsed during CONVERT aborts the sample and re-arms the history preload
        n = 0;
        while (!measure_o && n < 3000) begin
            tick();
            n++;
        end
        chk("rc_measure_seen", int'(measure_o), 1);
        tick();
        sensor_ready = 1'b0;
        repeat (3) tick();
        distance_raw = 22'd1000000;
        sensor_ready = 1'b1;
        repeat (40) tick();
        rst_n = 1'b0;
        #2;
        chk("rc_measure", int'(measure_o), 0);
        chk("rc_dist", int'(dist_cm_o), 0);
        chk("rc_avg", int'(avg_cm_o), 0);
        chk("rc_valid", int'(dist_valid_o), 0);
        chk("rc_near", int'(near_o), 0);
        chk("rc_err", int'(timeout_err_o), 0);
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (measure_o) break;
            tick();
            if (dist_valid_o) saw = 1'b1;
        end
        chk("rc_no_valid_after_abort", int'(saw), 0);
        model_reset();
        model_push(58000);
        run_sample("rc_first", 22'd58000, 3, 20, 20, 0, 0);
        model_push(0);
        run_sample("rc_second", 22'd0, 3, 0, 15, 1, 100);

        // Enable low: no requests; after re-enable the full period elapses first
        enable = 1'b0;
        saw = 1'b0;
        repeat (300) begin
            tick();
            if (measure_o) saw = 1'b1;
        end
        chk("en_low_no_measure", int'(saw), 0);
        enable = 1'b1;
        n = 0;
        while (!measure_o && n < 500) begin
            tick();
            n++;
        end
        chk("en_restart_delay", n, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/proximity_monitor.md
PROXIMITY_MONITOR -- requirements
Module: proximity_monitor

Interface
REQ-001 Parameter MEAS_PERIOD, default 3_000_000, minimum cycles between successive measure pulses (60 ms).
REQ-002 Parameter CYCLES_PER_CM, default 2900, echo-high clock cycles per cm of range.
REQ-003 Parameter TIMEOUT, default 1_500_000, cycles after measure with no completed echo before timeout_err is raised.
REQ-004 Parameter NEAR_CM, default 20, near-set threshold in cm.
REQ-005 Parameter HYST_CM, default 5, near-clear hysteresis in cm.
REQ-006 CLOCK_50  input  1  50 MHz clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high permits new measurements.
REQ-009 sensor_ready  input  1  ranging sensor idle/done indication.
REQ-010 distance_raw  input  22  sensor echo-high cycle count, valid while sensor_ready high after completion.
REQ-011 measure  output  1  one-cycle start request to sensor.
REQ-012 dist_cm  output  10  latest converted distance, cm.
REQ-013 avg_cm  output  10  4-sample moving average, cm.
REQ-014 dist_valid  output  1  one-cycle pulse, dist_cm/avg_cm/near updated this cycle.
REQ-015 near  output  1  hysteretic proximity flag.
REQ-016 timeout_err  output  1  sticky echo-timeout flag.

Function
REQ-017 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, CONVERT, FILTER.
REQ-018 Period counter: runs while enable high, saturates at MEAS_PERIOD-1, reloads to 0 in the cycle measure asserts; held at 0 while enable low.
REQ-019 IDLE->START when enable & sensor_ready & period counter == MEAS_PERIOD-1; otherwise wait (late sensor delays, never skips, the request).
REQ-020 START: measure=1 for exactly that cycle; ->WAIT_BUSY.
REQ-021 WAIT_BUSY->WAIT_DONE on first cycle sensor_ready low.
REQ-022 WAIT_DONE: on first cycle sensor_ready high, register distance_raw into remainder, clear quotient, ->CONVERT.
REQ-023 Timeout counter: cleared in START, increments in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT, timeout_err<=1, FSM keeps waiting; the eventually completed sample is discarded (WAIT_DONE->IDLE, no dist_valid).
REQ-024 timeout_err clears only on next non-timed-out dist_valid or reset.
REQ-025 CONVERT: each cycle, if remainder >= CYCLES_PER_CM and quotient < 1023, remainder -= CYCLES_PER_CM, quotient += 1; else ->FILTER.
REQ-026 Result: dist_cm = min(floor(raw/CYCLES_PER_CM), 1023); raw 0 gives 0 cm after one CONVERT cycle.
REQ-027 FILTER (one cycle): shift quotient into 4-entry history; first sample after reset preloads all 4 entries; sum 12 bits, avg = sum>>2 (truncate).
REQ-028 Cycle after FILTER: dist_cm, avg_cm, near registered; dist_valid=1 one cycle; ->IDLE.
REQ-029 Latency sensor_ready rise -> dist_valid = q+4 cycles, q = saturated quotient (max 1027).
REQ-030 near: set when new avg_cm < NEAR_CM; clear when new avg_cm >= NEAR_CM+HYST_CM; otherwise hold; updated only with dist_valid.
REQ-031 enable deassert mid-measurement: in-flight measurement completes normally; no new measure until enable high and period re-elapsed.
REQ-032 measure never asserted outside START; never two measure pulses without an intervening sensor completion.

Reset
REQ-033 rst_n low: state IDLE, all counters 0, history empty (preload armed), measure=0, dist_valid=0, dist_cm=0, avg_cm=0, near=0, timeout_err=0.
REQ-034 Reset mid-CONVERT or mid-wait aborts immediately; no dist_valid issued for aborted sample.

Verification
REQ-035 MEAS_PERIOD=100, enable high, sensor model ready -> measure pulses exactly every 100 cycles, width 1.
REQ-036 raw=29000 first sample -> dist_cm=10, avg_cm=10, near=1, dist_valid 14 cycles after ready rise.
REQ-037 Then raw=87000 x3 -> avg_cm 15, 20, 25; near 1, 1, 0.
REQ-038 raw=4_000_000 -> dist_cm=1023 (saturated); raw=0 -> dist_cm=0 after 4 cycles.
REQ-039 TIMEOUT=1000, sensor holds ready low 2000 cycles -> timeout_err=1 at cycle 1000, sample discarded, next good sample clears it.
REQ-040 rst_n pulsed during CONVERT -> all outputs 0, no dist_valid, next sample preloads history.
